// File: rtl/vga_scanout_if.sv
// Shared pixel-colour type plus the scanout bundle: frame-memory read port and video outputs.
// Master is the scanout engine; slave is the frame memory / DAC side.
package vga_scanout_pkg;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } vga_color_t;
endpackage

interface vga_scanout_if;
  import vga_scanout_pkg::*;

  logic [7:0] o_pxlX;
  logic [7:0] o_pxlY;
  vga_color_t i_color;
  vga_color_t o_color;
  logic       o_hsync;
  logic       o_vsync;
  logic       o_de;
  logic       o_vblank;
  logic       o_frame_start;
`ifdef VGA_SCANOUT_IRQ_EN
  logic       o_vblank_irq;
`endif

  modport master (
    input  i_color,
    output o_pxlX, o_pxlY, o_color, o_hsync, o_vsync, o_de, o_vblank, o_frame_start
`ifdef VGA_SCANOUT_IRQ_EN
    , output o_vblank_irq
`endif
  );

  modport slave (
    output i_color,
    input  o_pxlX, o_pxlY, o_color, o_hsync, o_vsync, o_de, o_vblank, o_frame_start
`ifdef VGA_SCANOUT_IRQ_EN
    , input o_vblank_irq
`endif
  );
endinterface

// File: rtl/vga_scanout.sv
// VGA timing generator and scanout; optional vblank IRQ output behind VGA_SCANOUT_IRQ_EN.
// Latency: pixel request same cycle as count; colour/sync/de appear RD_LAT+1 cycles after the count.
// Backpressure: i_en=0 freezes the counters; the video pipeline keeps shifting and settles on the held pixel.
module vga_scanout
  import vga_scanout_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SCALE_SHIFT = 2,
  parameter int RD_LAT      = 1
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_en,
  vga_scanout_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);

  // Video stage layout: {hsync_n, vsync_n, de}; blanked value has both syncs high.
  localparam logic [2:0] VID_IDLE = 3'b110;

  logic [HW-1:0] h_q, h_d, h_scaled;
  logic [VW-1:0] v_q, v_d, v_scaled;
  logic [7:0]    pxl_x_q, pxl_x_d;
  logic [7:0]    pxl_y_q, pxl_y_d;
  logic          vblank_q, vblank_d;
  logic          frame_start_q, frame_start_d;
  logic          active_d;
  logic [2:0]    vid_raw;
  logic [RD_LAT:0][2:0]   vid_q;
  logic [RD_LAT+1:0][2:0] vid_tap;
  vga_color_t    color_q, color_d;

  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (i_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  // Request coordinates come from the next count so they line up with the count once registered.
  always_comb begin
    active_d      = (h_d < H_ACT) && (v_d < V_ACT);
    h_scaled      = h_d >> SCALE_SHIFT;
    v_scaled      = v_d >> SCALE_SHIFT;
    pxl_x_d       = active_d ? 8'(h_scaled) : 8'd0;
    pxl_y_d       = active_d ? 8'(v_scaled) : 8'd0;
    vblank_d      = (v_d >= V_ACT);
    frame_start_d = i_en && (h_d == '0) && (v_d == '0);
  end

  // Tap RD_LAT gates the memory data arriving now; tap RD_LAT+1 lines up with registered colour.
  always_comb begin
    vid_raw = {~((h_q >= H_SS) && (h_q < H_SE)),
               ~((v_q >= V_SS) && (v_q < V_SE)),
               (h_q < H_ACT) && (v_q < V_ACT)};
    vid_tap = {vid_q, vid_raw};
    color_d = vid_tap[RD_LAT][0] ? bus.i_color : '0;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      h_q           <= '0;
      v_q           <= '0;
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
      vid_q         <= {(RD_LAT + 1){VID_IDLE}};
      color_q       <= '0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      vblank_q      <= vblank_d;
      frame_start_q <= frame_start_d;
      vid_q         <= vid_tap[RD_LAT:0];
      color_q       <= color_d;
    end
  end

  assign bus.o_pxlX        = pxl_x_q;
  assign bus.o_pxlY        = pxl_y_q;
  assign bus.o_vblank      = vblank_q;
  assign bus.o_frame_start = frame_start_q;
  assign bus.o_hsync       = vid_q[RD_LAT][2];
  assign bus.o_vsync       = vid_q[RD_LAT][1];
  assign bus.o_de          = vid_q[RD_LAT][0];
  assign bus.o_color       = color_q;

`ifdef VGA_SCANOUT_IRQ_EN
  logic vblank_irq_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      vblank_irq_q <= 1'b0;
    end else begin
      vblank_irq_q <= i_en && (h_d == '0) && (v_d == V_ACT);
    end
  end

  assign bus.o_vblank_irq = vblank_irq_q;
`endif
endmodule

// File: tb/tb_vga_scanout.sv
// Bench for vga_scanout on a shrunken 24x13 raster; a per-pixel reference model tracks raster position.
module tb_vga_scanout;
  import vga_scanout_pkg::*;

  localparam int HA = 16, HFP = 2, HS = 3, HBP = 3;
  localparam int VA = 8,  VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int SS = 2;

  typedef struct packed {
    logic [7:0]  px;
    logic [7:0]  py;
    logic        vb;
    logic        fs;
    logic        hs;
    logic        vs;
    logic        de;
    logic [11:0] col;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0;
  always #5 clk = ~clk;

  vga_scanout_if bus ();

  vga_scanout #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SCALE_SHIFT(SS), .RD_LAT(1)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .i_en     (en),
    .bus      (bus)
  );

  // Frame memory with one cycle of read latency: random table or echo of the column.
  vga_color_t mem_tab [16];
  logic       echo_mode = 1'b0;
  vga_color_t rd_q;
  always @(posedge clk)
    rd_q <= echo_mode ? vga_color_t'({4'd0, bus.o_pxlX})
                      : mem_tab[{bus.o_pxlY[1:0], bus.o_pxlX[1:0]}];
  assign bus.i_color = rd_q;

  int hm, vm;
  int hh[3], hv[3];
  bit hval[3];
  bit fs_exp, irq_exp;
  int checks = 0, passed = 0, cyc = 0;

  function automatic bit m_de(int h, int v);
    return (h < HA) && (v < VA);
  endfunction
  function automatic bit m_hs_n(int h);
    return !((h >= HA + HFP) && (h < HA + HFP + HS));
  endfunction
  function automatic bit m_vs_n(int v);
    return !((v >= VA + VFP) && (v < VA + VFP + VS));
  endfunction
  function automatic int m_px(int h, int v);
    return m_de(h, v) ? (h >> SS) : 0;
  endfunction
  function automatic int m_py(int h, int v);
    return m_de(h, v) ? (v >> SS) : 0;
  endfunction
  function automatic logic [11:0] m_mem(int h, int v);
    int px, py;
    px = m_px(h, v);
    py = m_py(h, v);
    return echo_mode ? 12'(px) : mem_tab[(py % 4) * 4 + (px % 4)];
  endfunction

  function automatic obs_t model_outs();
    obs_t o;
    o.px = 8'(m_px(hm, vm));
    o.py = 8'(m_py(hm, vm));
    o.vb = (vm >= VA);
    o.fs = fs_exp;
    if (hval[2]) begin
      o.hs  = m_hs_n(hh[2]);
      o.vs  = m_vs_n(hv[2]);
      o.de  = m_de(hh[2], hv[2]);
      o.col = o.de ? m_mem(hh[2], hv[2]) : 12'd0;
    end else begin
      o.hs = 1'b1; o.vs = 1'b1; o.de = 1'b0; o.col = 12'd0;
    end
    return o;
  endfunction

  function automatic obs_t dut_outs();
    obs_t o;
    o.px = bus.o_pxlX;   o.py = bus.o_pxlY;
    o.vb = bus.o_vblank; o.fs = bus.o_frame_start;
    o.hs = bus.o_hsync;  o.vs = bus.o_vsync;
    o.de = bus.o_de;     o.col = bus.o_color;
    return o;
  endfunction

  function automatic bit dut_irq();
`ifdef VGA_SCANOUT_IRQ_EN
    return bus.o_vblank_irq;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    hm = 0; vm = 0; fs_exp = 0; irq_exp = 0;
    for (int i = 0; i < 3; i++) begin
      hh[i] = 0; hv[i] = 0; hval[i] = 0;
    end
    hval[0] = 1;
  endtask

  task automatic tick(input bit e);
    en = e;
    @(posedge clk);
    fs_exp = 0; irq_exp = 0;
    if (e) begin
      hm++;
      if (hm == HT) begin
        hm = 0;
        vm = (vm + 1) % VT;
      end
      fs_exp  = (hm == 0) && (vm == 0);
      irq_exp = (hm == 0) && (vm == VA);
    end
    for (int i = 2; i > 0; i--) begin
      hh[i] = hh[i-1]; hv[i] = hv[i-1]; hval[i] = hval[i-1];
    end
    hh[0] = hm; hv[0] = vm; hval[0] = 1;
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.o_hsync !== 1'b1) $display("FAIL rst_hsync got=%b exp=1", bus.o_hsync); else passed++;
    checks++; if (bus.o_vsync !== 1'b1) $display("FAIL rst_vsync got=%b exp=1", bus.o_vsync); else passed++;
    checks++; if (bus.o_de !== 1'b0) $display("FAIL rst_de got=%b exp=0", bus.o_de); else passed++;
    checks++; if (bus.o_color !== 12'd0) $display("FAIL rst_color got=%h exp=0", bus.o_color); else passed++;
    checks++; if (bus.o_pxlX !== 8'd0 || bus.o_pxlY !== 8'd0)
      $display("FAIL rst_pxl got=%0d,%0d exp=0,0", bus.o_pxlX, bus.o_pxlY); else passed++;
    checks++; if (bus.o_vblank !== 1'b0 || bus.o_frame_start !== 1'b0)
      $display("FAIL rst_vb_fs got=%b%b exp=00", bus.o_vblank, bus.o_frame_start); else passed++;
    checks++; if (dut_irq() !== 1'b0) $display("FAIL rst_irq got=%b exp=0", dut_irq()); else passed++;
    model_reset();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL post_reset cyc=%0d got=%h exp=%h", cyc, dut_outs(), model_outs());
      else passed++;
    end
  endtask

  task automatic test_scan();
    for (int i = 0; i < 2000; i++) begin
      tick($urandom_range(0, 7) != 0);
      checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL scan cyc=%0d h=%0d v=%0d got=%h exp=%h", cyc, hm, vm, dut_outs(), model_outs());
      else passed++;
`ifdef VGA_SCANOUT_IRQ_EN
      checks++;
      if (dut_irq() !== irq_exp) $display("FAIL scan_irq cyc=%0d got=%b exp=%b", cyc, dut_irq(), irq_exp);
      else passed++;
`endif
    end
  endtask

  task automatic test_frame_period();
    int n, period, hs_low;
    n = 0;
    while (bus.o_frame_start !== 1'b1 && n < HT * VT + 10) begin tick(1); n++; end
    checks++;
    if (bus.o_frame_start !== 1'b1) $display("FAIL period_wait got=timeout exp=pulse");
    else passed++;
    period = 0; hs_low = 0;
    do begin
      tick(1); period++;
      if (bus.o_hsync === 1'b0) hs_low++;
    end while (bus.o_frame_start !== 1'b1 && period < 2 * HT * VT);
    checks++;
    if (period !== HT * VT) $display("FAIL frame_period got=%0d exp=%0d", period, HT * VT); else passed++;
    checks++;
    if (hs_low !== HS * VT) $display("FAIL hsync_low got=%0d exp=%0d", hs_low, HS * VT); else passed++;
  endtask

  task automatic test_echo();
    int n;
    echo_mode = 1'b1;
    repeat (3) tick(1);
    n = 0;
    while (!(hh[2] == 4 && hv[2] < VA) && n < 2 * HT * VT) begin tick(1); n++; end
    checks++;
    if (bus.o_color !== 12'd1 || bus.o_de !== 1'b1)
      $display("FAIL echo_h4 got=col %0d de %b exp=col 1 de 1", bus.o_color, bus.o_de);
    else passed++;
    n = 0;
    while (!(hh[2] == HA && hv[2] < VA) && n < 2 * HT) begin tick(1); n++; end
    checks++;
    if (bus.o_color !== 12'd0 || bus.o_de !== 1'b0)
      $display("FAIL echo_blank got=col %0d de %b exp=col 0 de 0", bus.o_color, bus.o_de);
    else passed++;
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    while (!(hm == HT - 1 && vm == VT - 1) && n < 2 * HT * VT) begin tick(1); n++; end
    checks++;
    if (bus.o_vblank !== 1'b1 || bus.o_frame_start !== 1'b0)
      $display("FAIL wrap_before got=vb %b fs %b exp=vb 1 fs 0", bus.o_vblank, bus.o_frame_start);
    else passed++;
    tick(1);
    checks++;
    if (bus.o_frame_start !== 1'b1 || bus.o_vblank !== 1'b0)
      $display("FAIL wrap_after got=fs %b vb %b exp=fs 1 vb 0", bus.o_frame_start, bus.o_vblank);
    else passed++;
    checks++;
    if (bus.o_pxlX !== 8'd0 || bus.o_pxlY !== 8'd0)
      $display("FAIL wrap_pxl got=%0d,%0d exp=0,0", bus.o_pxlX, bus.o_pxlY);
    else passed++;
  endtask

  task automatic test_freeze();
    int n;
    logic [11:0] held_col;
    n = 0;
    while (!(hm == 11 && vm == 3) && n < 2 * HT * VT) begin tick(1); n++; end
    held_col = m_mem(11, 3);
    for (int i = 0; i < 50; i++) begin
      tick(0);
      checks++;
      if (bus.o_pxlX !== 8'd2 || bus.o_pxlY !== 8'd0 || bus.o_frame_start !== 1'b0 || bus.o_vblank !== 1'b0)
        $display("FAIL freeze_ctr i=%0d got=x%0d y%0d fs%b vb%b exp=x2 y0 fs0 vb0", i,
                 bus.o_pxlX, bus.o_pxlY, bus.o_frame_start, bus.o_vblank);
      else passed++;
      if (i >= 2) begin
        checks++;
        if (bus.o_de !== 1'b1 || bus.o_color !== held_col || bus.o_hsync !== 1'b1)
          $display("FAIL freeze_vid i=%0d got=de%b col%h hs%b exp=de1 col%h hs1", i,
                   bus.o_de, bus.o_color, bus.o_hsync, held_col);
        else passed++;
      end
    end
    tick(1);
    checks++;
    if (bus.o_pxlX !== 8'd3) $display("FAIL freeze_resume got=%0d exp=3", bus.o_pxlX); else passed++;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++;
      if (dut_outs() !== model_outs())
        $display("FAIL resume cyc=%0d got=%h exp=%h", cyc, dut_outs(), model_outs());
      else passed++;
    end
  endtask

  task automatic test_reset_midframe();
    int n, pulses;
    n = 0;
    while (!(hm == 20 && vm == 5) && n < 2 * HT * VT) begin tick(1); n++; end
    checks++;
    if (bus.o_hsync !== 1'b0) $display("FAIL mid_pre_hsync got=%b exp=0", bus.o_hsync); else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.o_hsync !== 1'b1 || bus.o_vsync !== 1'b1 || bus.o_color !== 12'd0 || bus.o_de !== 1'b0)
      $display("FAIL mid_reset got=hs%b vs%b col%h de%b exp=hs1 vs1 col0 de0",
               bus.o_hsync, bus.o_vsync, bus.o_color, bus.o_de);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < HT * VT - 1; i++) begin
      tick(1);
      if (bus.o_frame_start === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) $display("FAIL mid_no_fs got=%0d exp=0", pulses); else passed++;
    tick(1);
    checks++;
    if (bus.o_frame_start !== 1'b1) $display("FAIL mid_first_fs got=%b exp=1", bus.o_frame_start); else passed++;
  endtask

`ifdef VGA_SCANOUT_IRQ_EN
  task automatic test_irq();
    int pulses;
    pulses = 0;
    for (int i = 0; i < HT * VT; i++) begin
      tick(1);
      if (bus.o_vblank_irq === 1'b1) begin
        pulses++;
        checks++;
        if (!(hm == 0 && vm == VA)) $display("FAIL irq_pos got=h%0d v%0d exp=h0 v%0d", hm, vm, VA);
        else passed++;
      end
    end
    checks++;
    if (pulses !== 1) $display("FAIL irq_count got=%0d exp=1", pulses); else passed++;
  endtask
`endif

  initial begin
    for (int i = 0; i < 16; i++) mem_tab[i] = vga_color_t'(12'($urandom));
    model_reset();
    test_reset();
    test_scan();
    test_frame_period();
    test_echo();
    test_wrap();
    test_freeze();
    test_reset_midframe();
`ifdef VGA_SCANOUT_IRQ_EN
    test_irq();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 640: visible pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16: horizontal front porch, in pixels.
REQ-003 The block SHALL have parameter H_SYNC, default 96: hsync width, in pixels.
REQ-004 The block SHALL have parameter H_BP, default 48: horizontal back porch, in pixels.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480: visible lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10: vertical front porch, in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2: vsync width, in lines.
REQ-008 The block SHALL have parameter V_BP, default 33: vertical back porch, in lines.
REQ-009 The block SHALL have parameter SCALE_SHIFT, default 2: log2 of the pixel replication factor (640x480 -> 160x120).
REQ-010 The block SHALL have parameter RD_LAT, default 1: frame-memory read latency, in i_clk cycles, from pxlX/pxlY to color.
REQ-011 The block SHALL have these ports:
- i_clk  in  1  pixel clock (same clock as the frame memory's VGA read port)
- i_reset_n  in  1  asynchronous, active-low reset
- i_en  in  1  scan enable
- o_pxlX  out  8  frame-memory column request, h_cnt >> SCALE_SHIFT
- o_pxlY  out  8  frame-memory row request, v_cnt >> SCALE_SHIFT
- i_color  in  vga_color_t  pixel color returned by frame memory
- o_color  out  vga_color_t  color to DAC; zero when blanked
- o_hsync  out  1  horizontal sync, active low
- o_vsync  out  1  vertical sync, active low
- o_de  out  1  data-enable, high for visible pixels
- o_vblank  out  1  level, high while v_cnt >= V_ACTIVE
- o_frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0

Function
REQ-012 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800), then wrap to 0; v_cnt SHALL increment only on the h_cnt wrap.
REQ-013 v_cnt SHALL count 0..V_TOTAL-1 (525); when h_cnt and v_cnt both wrap in the same cycle, both SHALL go to 0.
REQ-014 When i_en=0, both counters SHALL hold their values; when i_en returns to 1, counting SHALL resume from the held values.
REQ-015 o_pxlX and o_pxlY SHALL be registered and valid in the same cycle as the count that produced them; outside the active region they SHALL be clamped to 0.
REQ-016 The raw sync signals SHALL be: hsync active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; de when h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-017 hsync, vsync and de SHALL be delayed through a shift pipeline of RD_LAT+1 stages so that they align with o_color.
REQ-018 o_color SHALL be registered as follows: i_color when the delayed de=1, else 0.
REQ-019 o_vblank and o_frame_start SHALL be derived from the undelayed counters (early warning for the CPU buffer swap).
REQ-020 o_frame_start SHALL pulse only when the counters advance into (0,0) with i_en=1, and SHALL NOT pulse when coming out of reset.

Reset
REQ-021 While i_reset_n=0 the block SHALL asynchronously clear h_cnt, v_cnt, o_pxlX, o_pxlY, o_color, o_de and o_frame_start to 0, drive o_hsync and o_vsync to 1, and drive o_vblank to 0; all pipeline stages SHALL reset to the inactive (blanked) state.
REQ-022 After reset deassertion, the first counting cycle SHALL be h_cnt=0, v_cnt=0; a reset asserted mid-frame SHALL abort the frame immediately.

Configuration
REQ-023 With macro VGA_SCANOUT_IRQ_EN defined, the block SHALL add port o_vblank_irq (out, 1), which pulses for one cycle when v_cnt transitions to V_ACTIVE at h_cnt=0; without the macro, the port and its logic SHALL be absent.

Verification
REQ-024 Reset then i_en=1 for 420000 cycles -> o_frame_start pulses every 420000 cycles (800x525); o_hsync is low for 96 cycles per 800.
REQ-025 Drive i_color=pxlX value (echo model, RD_LAT=1) -> o_color at the 5th visible pixel (h=4) equals 1, aligned with o_de; o_color=0 when o_de=0.
REQ-026 At h_cnt=799, v_cnt=524 -> the next cycle gives h=0, v=0, o_frame_start=1, o_vblank=0.
REQ-027 Set i_en=0 at h=300 for 50 cycles -> counters and outputs are frozen; after resume, h=301.
REQ-028 Assert i_reset_n=0 at v=200 -> in the same cycle o_hsync=1, o_vsync=1, o_color=0; after release, no o_frame_start pulse occurs until the first full frame completes.
REQ-029 With VGA_SCANOUT_IRQ_EN defined -> o_vblank_irq is a single pulse at v=480, h=0, exactly once per frame.
